// File: rtl/edge_event_encoder.sv
// edge_event_encoder: turns 0->1 transitions on a per-row flag vector into
// timestamped {row, stamp} events. Events are queued in a small FIFO and
// delivered over a first-word-fall-through valid/ready stream. Rises that
// arrive while their row still has an unserviced event are merged into it
// and counted in a saturating drop counter.
module edge_event_encoder #(
  parameter int PIXEL_HEIGHT = 5,
  parameter int STAMP_WIDTH  = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int ROW_WIDTH    = $clog2(PIXEL_HEIGHT)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [PIXEL_HEIGHT-1:0]       result_in,
  output logic                          event_valid,
  input  logic                          event_ready,
  output logic [ROW_WIDTH-1:0]          event_row,
  output logic [STAMP_WIDTH-1:0]        event_stamp,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = ROW_WIDTH + STAMP_WIDTH;
  localparam int CNT_W = $clog2(PIXEL_HEIGHT + 1);
  localparam int SUM_W = ((CNT_W > 8) ? CNT_W : 8) + 1;

  // Saturating add of this cycle's merge count onto the 8-bit drop counter.
  function automatic logic [7:0] sat_add_drop(input logic [7:0] acc,
                                              input logic [CNT_W-1:0] inc);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(acc) + SUM_W'(inc);
    if (sum > SUM_W'(255)) begin
      return 8'hFF;
    end
    return sum[7:0];
  endfunction

  logic [PIXEL_HEIGHT-1:0] prev_q;
  logic [PIXEL_HEIGHT-1:0] pending_q, pending_d;
  logic [STAMP_WIDTH-1:0]  stamp_reg_q [PIXEL_HEIGHT];
  logic [STAMP_WIDTH-1:0]  stamp_reg_d [PIXEL_HEIGHT];
  logic [STAMP_WIDTH-1:0]  stamp_cnt_q;
  logic [ENT_W-1:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]        level_q, level_d;
  logic [7:0]              drop_q;

  logic [PIXEL_HEIGHT-1:0] rise;
  logic [PIXEL_HEIGHT-1:0] grant;
  logic [PIXEL_HEIGHT-1:0] svc;
  logic [ROW_WIDTH-1:0]    sel_row;
  logic [STAMP_WIDTH-1:0]  sel_stamp;
  logic [CNT_W-1:0]        merge_cnt;
  logic                    full;
  logic                    push;
  logic                    pop;
  logic [ROW_WIDTH-1:0]    head_row;
  logic [STAMP_WIDTH-1:0]  head_stamp;

  assign rise  = result_in & ~prev_q;
  // Isolate the lowest-index pending row (two's-complement trick).
  assign grant = pending_q & (~pending_q + PIXEL_HEIGHT'(1));
  // Fullness is judged before any pop, so a pop never frees a slot for a
  // same-cycle push.
  assign full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign push  = (pending_q != '0) && !full;
  assign pop   = (level_q != '0) && event_ready;
  assign svc   = push ? grant : '0;

  // Encode the granted row and fetch its captured stamp.
  always_comb begin
    sel_row   = '0;
    sel_stamp = '0;
    for (int r = 0; r < PIXEL_HEIGHT; r++) begin
      if (grant[r]) begin
        sel_row   = sel_row | ROW_WIDTH'(r);
        sel_stamp = sel_stamp | stamp_reg_q[r];
      end
    end
  end

  // Per-row pending/stamp update: service clears, rise sets, rise on a still-pending row merges.
  always_comb begin
    pending_d   = pending_q;
    stamp_reg_d = stamp_reg_q;
    merge_cnt   = '0;
    for (int r = 0; r < PIXEL_HEIGHT; r++) begin
      if (svc[r]) begin
        pending_d[r] = 1'b0;
      end
      if (rise[r]) begin
        if (pending_q[r] && !svc[r]) begin
          merge_cnt = merge_cnt + CNT_W'(1);
        end else begin
          pending_d[r]   = 1'b1;
          stamp_reg_d[r] = stamp_cnt_q;
        end
      end
    end
  end

  // Occupancy follows push/pop; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state: flag history, pending set, timestamp, FIFO pointers, drop counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q      <= '0;
      pending_q   <= '0;
      stamp_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      drop_q      <= '0;
    end else begin
      prev_q      <= result_in;
      pending_q   <= pending_d;
      stamp_cnt_q <= stamp_cnt_q + STAMP_WIDTH'(1);
      level_q     <= level_d;
      drop_q      <= sat_add_drop(drop_q, merge_cnt);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Captured stamps are plain data; pending_q qualifies them, so no reset is needed.
  always_ff @(posedge clock) begin
    for (int r = 0; r < PIXEL_HEIGHT; r++) begin
      stamp_reg_q[r] <= stamp_reg_d[r];
    end
  end

  // FIFO storage write; entries are only observed while counted in level_q.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {sel_row, sel_stamp};
    end
  end

  assign {head_row, head_stamp} = mem_q[rd_ptr_q];

  // Head is forced to zero while empty so stale storage never shows on the port.
  assign event_valid = (level_q != '0);
  assign event_row   = event_valid ? head_row   : '0;
  assign event_stamp = event_valid ? head_stamp : '0;
  assign fifo_level  = level_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_edge_event_encoder.sv
// Testbench for edge_event_encoder: scenario tasks drive stimulus and push
// expected events into a scoreboard queue; a monitor pops and compares on
// every accepted output transfer.
module tb_edge_event_encoder;

  logic        clock;
  logic        reset;
  logic [4:0]  result_in;
  logic        event_valid;
  logic        event_ready;
  logic [2:0]  event_row;
  logic [15:0] event_stamp;
  logic [2:0]  fifo_level;
  logic [7:0]  drop_count;

  typedef struct packed {
    logic [2:0]  row;
    logic [15:0] stamp;
  } ev_t;

  ev_t         exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] tb_cnt;

  edge_event_encoder #(
    .PIXEL_HEIGHT(5),
    .STAMP_WIDTH (16),
    .FIFO_DEPTH  (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .result_in  (result_in),
    .event_valid(event_valid),
    .event_ready(event_ready),
    .event_row  (event_row),
    .event_stamp(event_stamp),
    .fifo_level (fifo_level),
    .drop_count (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference free-running cycle stamp.
  always @(posedge clock) begin
    if (reset) tb_cnt <= 16'd0;
    else       tb_cnt <= tb_cnt + 16'd1;
  end

  // Scoreboard monitor: every accepted transfer must match the oldest expectation.
  always @(negedge clock) begin
    if (!reset && event_valid === 1'b1 && event_ready === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got row=%0d stamp=%h, required no event", event_row, event_stamp);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (event_row !== e.row || event_stamp !== e.stamp) begin
          n_fail++;
          $display("FAIL sb_event: got row=%0d stamp=%h, required row=%0d stamp=%h",
                   event_row, event_stamp, e.row, e.stamp);
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] r, input logic [15:0] s);
    ev_t e;
    e.row   = r;
    e.stamp = s;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input logic [4:0] hold);
    reset     = 1'b1;
    result_in = hold;
    tick();
    tick();
    exp_q.delete();
    reset = 1'b0;
  endtask

  task automatic wait_stamp(input logic [15:0] v);
    int n = 0;
    while (tb_cnt !== v && n < 70000) begin
      tick();
      n++;
    end
    n_tests++;
    if (tb_cnt !== v) begin
      n_fail++;
      $display("FAIL wait_stamp: stamp=%h, required %h", tb_cnt, v);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    event_ready = 1'b1;
    while ((exp_q.size() != 0 || event_valid === 1'b1) && n < budget) begin
      tick();
      n++;
    end
    repeat (4) tick();
    n_tests++;
    if (exp_q.size() != 0 || event_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: %0d events outstanding, event_valid=%b, required 0 and 0",
               exp_q.size(), event_valid);
    end
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    result_in   = 5'b0;
    event_ready = 1'b0;
    tick();
    tick();
    tick();
    @(negedge clock);
    n_tests++;
    if (event_valid !== 1'b0 || fifo_level !== 3'd0 || drop_count !== 8'd0 ||
        event_row !== 3'd0 || event_stamp !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b level=%0d drop=%0d row=%0d stamp=%h, required all zero",
               event_valid, fifo_level, drop_count, event_row, event_stamp);
    end
    tick();
    exp_q.delete();
    reset = 1'b0;
  endtask

  task automatic test_single();
    event_ready = 1'b1;
    wait_stamp(16'd3);
    result_in = 5'b00100;
    push_exp(3'd2, 16'd3);
    tick();
    result_in = 5'b00000;
    @(negedge clock);
    n_tests++;
    if (event_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_latency1: event_valid=%b, required 0", event_valid);
    end
    tick();
    @(negedge clock);
    n_tests++;
    if (event_valid !== 1'b1 || event_row !== 3'd2 || event_stamp !== 16'd3) begin
      n_fail++;
      $display("FAIL single_latency2: valid=%b row=%0d stamp=%h, required 1 2 0003",
               event_valid, event_row, event_stamp);
    end
    drain(10);
    n_tests++;
    if (drop_count !== 8'd0) begin
      n_fail++;
      $display("FAIL single_drop: drop_count=%0d, required 0", drop_count);
    end
  endtask

  task automatic test_multi();
    logic [2:0] rows [3];
    rows = '{3'd0, 3'd1, 3'd4};
    do_reset(5'b0);
    event_ready = 1'b1;
    wait_stamp(16'd10);
    result_in = 5'b10011;
    push_exp(3'd0, 16'd10);
    push_exp(3'd1, 16'd10);
    push_exp(3'd4, 16'd10);
    tick();
    result_in = 5'b00000;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clock);
      n_tests++;
      if (event_valid !== 1'b1 || event_row !== rows[k] || event_stamp !== 16'd10) begin
        n_fail++;
        $display("FAIL multi_seq%0d: valid=%b row=%0d stamp=%h, required 1 %0d 000a",
                 k, event_valid, event_row, event_stamp, rows[k]);
      end
    end
    drain(10);
  endtask

  task automatic test_full_merge();
    logic [15:0] s [6];
    do_reset(5'b0);
    event_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      result_in = 5'b00001 << i;
      s[i] = tb_cnt;
      tick();
      result_in = 5'b0;
      tick();
    end
    result_in = 5'b00001;
    s[5] = tb_cnt;
    tick();
    result_in = 5'b0;
    tick();
    result_in = 5'b00001;
    tick();
    result_in = 5'b0;
    tick();
    tick();
    @(negedge clock);
    n_tests++;
    if (fifo_level !== 3'd4 || event_valid !== 1'b1 || event_row !== 3'd0 || event_stamp !== s[0]) begin
      n_fail++;
      $display("FAIL full_level: level=%0d valid=%b row=%0d stamp=%h, required 4 1 0 %h",
               fifo_level, event_valid, event_row, event_stamp, s[0]);
    end
    n_tests++;
    if (drop_count !== 8'd1) begin
      n_fail++;
      $display("FAIL merge_drop: drop_count=%0d, required 1", drop_count);
    end
    push_exp(3'd0, s[0]);
    push_exp(3'd1, s[1]);
    push_exp(3'd2, s[2]);
    push_exp(3'd3, s[3]);
    push_exp(3'd0, s[5]);
    push_exp(3'd4, s[4]);
    tick();
    drain(30);
  endtask

  task automatic test_full_pop();
    logic [15:0] s [5];
    do_reset(5'b0);
    event_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      result_in = 5'b00001 << i;
      s[i] = tb_cnt;
      push_exp(3'(i), s[i]);
      tick();
      result_in = 5'b0;
      tick();
    end
    tick();
    event_ready = 1'b1;
    @(negedge clock);
    n_tests++;
    if (fifo_level !== 3'd4) begin
      n_fail++;
      $display("FAIL fullpop_l4: level=%0d, required 4", fifo_level);
    end
    tick();
    event_ready = 1'b0;
    @(negedge clock);
    n_tests++;
    if (fifo_level !== 3'd3) begin
      n_fail++;
      $display("FAIL fullpop_l3: level=%0d, required 3", fifo_level);
    end
    tick();
    @(negedge clock);
    n_tests++;
    if (fifo_level !== 3'd4) begin
      n_fail++;
      $display("FAIL fullpop_l4b: level=%0d, required 4", fifo_level);
    end
    tick();
    drain(30);
  endtask

  task automatic test_wrap();
    bit seen1 = 0;
    bit seen2 = 0;
    event_ready = 1'b1;
    result_in   = 5'b0;
    wait_stamp(16'hFFFF);
    result_in = 5'b00010;
    push_exp(3'd1, 16'hFFFF);
    tick();
    result_in = 5'b00110;
    push_exp(3'd2, 16'h0000);
    tick();
    result_in = 5'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      if (event_valid === 1'b1 && event_row === 3'd1) begin
        seen1 = 1;
        n_tests++;
        if (event_stamp !== 16'hFFFF) begin
          n_fail++;
          $display("FAIL wrap_ffff: stamp=%h, required ffff", event_stamp);
        end
      end
      if (event_valid === 1'b1 && event_row === 3'd2) begin
        seen2 = 1;
        n_tests++;
        if (event_stamp !== 16'h0000) begin
          n_fail++;
          $display("FAIL wrap_zero: stamp=%h, required 0000", event_stamp);
        end
      end
      tick();
    end
    n_tests++;
    if (!(seen1 && seen2)) begin
      n_fail++;
      $display("FAIL wrap_seen: row1=%0d row2=%0d, required 1 1", seen1, seen2);
    end
    drain(10);
  endtask

  task automatic test_reset_mid();
    event_ready = 1'b0;
    result_in   = 5'b11111;
    tick();
    tick();
    tick();
    tick();
    @(negedge clock);
    n_tests++;
    if (fifo_level !== 3'd3) begin
      n_fail++;
      $display("FAIL mid_pre_level: level=%0d, required 3", fifo_level);
    end
    reset = 1'b1;
    tick();
    exp_q.delete();
    @(negedge clock);
    n_tests++;
    if (event_valid !== 1'b0 || fifo_level !== 3'd0 || drop_count !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b level=%0d drop=%0d, required 0 0 0",
               event_valid, fifo_level, drop_count);
    end
    tick();
    reset = 1'b0;
    for (int r = 0; r < 5; r++) push_exp(3'(r), 16'd0);
    drain(30);
    n_tests++;
    if (drop_count !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_drop: drop_count=%0d, required 0", drop_count);
    end
    result_in = 5'b0;
  endtask

  initial begin
    reset       = 1'b1;
    result_in   = 5'b0;
    event_ready = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_full_merge();
    test_full_pop();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
